// File: rtl/cadence_xform.sv
// Period-to-cadence transform: cadence = min(OUT_MAX, BASE + K/period), reciprocal by restoring divider.
// Optional macro CADENCE_AVG_EN enables a 4-entry moving average of the clamped results.
module cadence_xform #(
   parameter int PER_W   = 8,
   parameter int OUT_W   = 5,
   parameter int K_W     = 12,
   parameter int K       = 256,
   parameter int BASE    = 15,
   parameter int OUT_MAX = 31,
   parameter int MIN_PER = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PER_W-1:0] cadence_per,
   input  logic             per_vld,
   output logic             per_rdy,
   output logic [OUT_W-1:0] cadence,
   output logic             cadence_vld,
   output logic             busy
);

   localparam int CNT_W = $clog2(K_W + 1);
   localparam logic [CNT_W-1:0] L_CNT_TOP = CNT_W'(K_W - 1);
   localparam logic [CNT_W-1:0] L_CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] L_CNT_ZERO = CNT_W'(0);
   localparam logic [K_W-1:0]   L_K       = K_W'(K);
   localparam logic [K_W:0]     L_BASE    = (K_W + 1)'(BASE);
   localparam logic [K_W:0]     L_MAX     = (K_W + 1)'(OUT_MAX);
   localparam logic [OUT_W-1:0] L_MAX_OUT = OUT_W'(OUT_MAX);
   localparam logic [PER_W-1:0] L_MIN_PER = PER_W'(MIN_PER);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nx;
   logic [PER_W-1:0]   r_rem;
   logic [K_W-1:0]     r_dvd;
   logic [PER_W-1:0]   r_div;
   logic [K_W-1:0]     r_q;
   logic [CNT_W-1:0]   r_cnt;
   logic [OUT_W-1:0]   r_cadence;
   logic               r_cadence_vld;

   logic [PER_W:0]     w_rem_sh;
   logic               w_ge;
   logic [PER_W-1:0]   w_rem_nx;
   logic [K_W:0]       w_sum;
   logic [OUT_W-1:0]   w_clamp;
   logic [OUT_W-1:0]   w_result;
   logic               w_accept;
   logic               w_short;

   assign w_accept = per_vld & per_rdy;
   assign w_short  = (cadence_per < L_MIN_PER);

   // Restoring step: the remainder is always below the divisor, so the
   // subtraction fits in PER_W bits once the shifted value is known to be >= divisor.
   assign w_rem_sh = {r_rem, r_dvd[K_W-1]};
   assign w_ge     = (w_rem_sh >= {1'b0, r_div});
   assign w_rem_nx = w_ge ? (w_rem_sh[PER_W-1:0] - r_div) : w_rem_sh[PER_W-1:0];

   assign w_sum    = {1'b0, r_q} + L_BASE;
   assign w_clamp  = (w_sum > L_MAX) ? L_MAX_OUT : w_sum[OUT_W-1:0];

`ifdef CADENCE_AVG_EN
   // The newest clamped value plus these three older ones form the 4-entry window.
   logic [OUT_W-1:0] r_hist [3];
   logic [OUT_W+1:0] w_avg_sum;

   assign w_avg_sum = (OUT_W + 2)'(w_clamp) + (OUT_W + 2)'(r_hist[0])
                    + (OUT_W + 2)'(r_hist[1]) + (OUT_W + 2)'(r_hist[2]);
   assign w_result  = OUT_W'(w_avg_sum >> 2);

   // History shift register, advanced once per completed conversion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hist[0] <= {OUT_W{1'b0}};
         r_hist[1] <= {OUT_W{1'b0}};
         r_hist[2] <= {OUT_W{1'b0}};
      end else if (r_state == S_DONE) begin
         r_hist[0] <= w_clamp;
         r_hist[1] <= r_hist[0];
         r_hist[2] <= r_hist[1];
      end
   end
`else
   assign w_result = w_clamp;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE: begin
            if (per_vld) begin
               w_state_nx = w_short ? S_DONE : S_DIV;
            end else begin
               w_state_nx = S_IDLE;
            end
         end
         S_DIV: begin
            if (r_cnt == L_CNT_ZERO) begin
               w_state_nx = S_DONE;
            end else begin
               w_state_nx = S_DIV;
            end
         end
         S_DONE:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   // State-decoded handshake outputs.
   always_comb begin
      per_rdy = 1'b0;
      busy    = 1'b0;
      case (r_state)
         S_IDLE:  per_rdy = 1'b1;
         S_DIV:   busy    = 1'b1;
         S_DONE:  per_rdy = 1'b0;
         default: per_rdy = 1'b0;
      endcase
   end

   // Divider datapath; short periods bypass the divider with a saturated quotient.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem <= {PER_W{1'b0}};
         r_dvd <= {K_W{1'b0}};
         r_div <= {PER_W{1'b0}};
         r_q   <= {K_W{1'b0}};
         r_cnt <= L_CNT_ZERO;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_short) begin
                     r_q <= {K_W{1'b1}};
                  end else begin
                     r_rem <= {PER_W{1'b0}};
                     r_dvd <= L_K;
                     r_div <= cadence_per;
                     r_cnt <= L_CNT_TOP;
                  end
               end
            end
            S_DIV: begin
               r_rem <= w_rem_nx;
               r_dvd <= {r_dvd[K_W-2:0], 1'b0};
               r_q   <= {r_q[K_W-2:0], w_ge};
               r_cnt <= r_cnt - L_CNT_ONE;
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   // Result register and one-cycle strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cadence     <= {OUT_W{1'b0}};
         r_cadence_vld <= 1'b0;
      end else begin
         r_cadence_vld <= (r_state == S_DONE);
         if (r_state == S_DONE) begin
            r_cadence <= w_result;
         end
      end
   end

   assign cadence     = r_cadence;
   assign cadence_vld = r_cadence_vld;

endmodule

// File: tb/tb_cadence_xform.sv
// Self-checking bench for cadence_xform against an arithmetic reference model.
module tb_cadence_xform;

   localparam int M_K       = 256;
   localparam int M_BASE    = 15;
   localparam int M_MAX     = 31;
   localparam int M_MIN     = 8;
   localparam int M_QSAT    = 4095;
   localparam int DIV_LAT   = 13;

   logic       clk;
   logic       rst_n;
   logic [7:0] cadence_per;
   logic       per_vld;
   logic       per_rdy;
   logic [4:0] cadence;
   logic       cadence_vld;
   logic       busy;

   int checks;
   int failures;
   int hist[4];

   cadence_xform dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cadence_per (cadence_per),
      .per_vld     (per_vld),
      .per_rdy     (per_rdy),
      .cadence     (cadence),
      .cadence_vld (cadence_vld),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) hist[i] = 0;
   endfunction

   function automatic int model_conv(input int p);
      int q;
      int s;
      int c;
      q = (p < M_MIN) ? M_QSAT : (M_K / p);
      s = M_BASE + q;
      c = (s > M_MAX) ? M_MAX : s;
`ifdef CADENCE_AVG_EN
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = c;
      return (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
`else
      return c;
`endif
   endfunction

   // Runs one conversion; reports latency (0 = no strobe within the budget).
   task automatic convert(input logic [7:0] p, output int lat, output logic [4:0] res,
                          output bit rdy_ok, output bit busy_seen, output bit rdy_at_vld);
      int w;
      @(negedge clk);
      per_vld = 1'b1;
      cadence_per = p;
      w = 0;
      while (!per_rdy && w < 40) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      @(negedge clk);
      per_vld = 1'b0;
      cadence_per = 8'($urandom);
      lat = 0;
      res = 5'd0;
      rdy_ok = 1'b1;
      busy_seen = 1'b0;
      rdy_at_vld = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (cadence_vld) begin
            lat = k;
            res = cadence;
            rdy_at_vld = per_rdy;
            break;
         end
         if (per_rdy) rdy_ok = 1'b0;
         if (busy) busy_seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      per_vld = 1'b0;
      cadence_per = 8'h00;
      model_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (per_rdy !== 1'b1 || busy !== 1'b0 || cadence_vld !== 1'b0 || cadence !== 5'd0) begin
         failures++;
         $display("FAIL reset_state: rdy=%b busy=%b vld=%b cad=%h, want 1 0 0 00",
                  per_rdy, busy, cadence_vld, cadence);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (per_rdy !== 1'b1 || cadence_vld !== 1'b0) begin
         failures++;
         $display("FAIL post_reset: rdy=%b vld=%b, want 1 0", per_rdy, cadence_vld);
      end
   endtask

   task automatic run_one(input string name, input logic [7:0] p);
      int lat;
      int exp_lat;
      logic [4:0] res;
      logic [4:0] exp_v;
      bit rdy_ok;
      bit busy_seen;
      bit rdy_vld;
      exp_v = 5'(model_conv(int'(p)));
      exp_lat = (int'(p) < M_MIN) ? 1 : DIV_LAT;
      convert(p, lat, res, rdy_ok, busy_seen, rdy_vld);
      checks++;
      if (lat !== exp_lat) begin
         failures++;
         $display("FAIL %s_latency per=%h: got %0d want %0d", name, p, lat, exp_lat);
      end
      checks++;
      if (res !== exp_v) begin
         failures++;
         $display("FAIL %s_value per=%h: got %h want %h", name, p, res, exp_v);
      end
      checks++;
      if (rdy_ok !== 1'b1 || rdy_vld !== 1'b1) begin
         failures++;
         $display("FAIL %s_rdy per=%h: low_while_busy=%b high_at_vld=%b want 1 1",
                  name, p, rdy_ok, rdy_vld);
      end
      checks++;
      if (busy_seen !== (exp_lat == DIV_LAT)) begin
         failures++;
         $display("FAIL %s_busy per=%h: seen=%b want %b", name, p, busy_seen, exp_lat == DIV_LAT);
      end
   endtask

   task automatic test_divide();
      logic [4:0] held;
      run_one("div", 8'h10);
      run_one("div", 8'h80);
      run_one("div", 8'hFF);
      held = cadence;
      repeat (5) begin
         @(negedge clk);
         checks++;
         if (cadence_vld !== 1'b0 || cadence !== held) begin
            failures++;
            $display("FAIL hold: vld=%b cad=%h want 0 %h", cadence_vld, cadence, held);
         end
      end
   endtask

   task automatic test_saturate();
      run_one("sat", 8'h00);
      run_one("sat", 8'h07);
      run_one("sat", 8'h08);
   endtask

   task automatic test_random();
      logic [7:0] p;
      for (int i = 0; i < 16; i++) begin
         if ($urandom_range(0, 3) == 0) p = 8'($urandom_range(0, 12));
         else p = 8'($urandom_range(0, 255));
         run_one("rand", p);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] vals[3];
      int exp_q[$];
      int acc_q[$];
      int idx;
      int got;
      int acc_c;
      int exp_v;
      bit acc;
      vals[0] = 8'h80;
      vals[1] = 8'h10;
      vals[2] = 8'h80;
      idx = 0;
      got = 0;
      @(negedge clk);
      per_vld = 1'b1;
      cadence_per = vals[0];
      for (int c = 0; c < 60; c++) begin
         if (cadence_vld) begin
            got++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL b2b_extra: unexpected strobe cad=%h at cycle %0d", cadence, c);
            end else begin
               exp_v = exp_q.pop_front();
               acc_c = acc_q.pop_front();
               if (cadence !== 5'(exp_v) || (c - acc_c - 1) != DIV_LAT) begin
                  failures++;
                  $display("FAIL b2b_result: got %h lat %0d want %h lat %0d",
                           cadence, c - acc_c - 1, 5'(exp_v), DIV_LAT);
               end
            end
         end
         acc = per_rdy && (idx < 3);
         if (acc) begin
            exp_q.push_back(model_conv(int'(vals[idx])));
            acc_q.push_back(c);
         end
         @(posedge clk);
         #1;
         if (acc) begin
            idx++;
            if (idx < 3) cadence_per = vals[idx];
            else per_vld = 1'b0;
         end
         @(negedge clk);
      end
      checks++;
      if (got != 3 || idx != 3) begin
         failures++;
         $display("FAIL b2b_count: strobes=%0d accepts=%0d want 3 3", got, idx);
      end
   endtask

   task automatic test_reset_mid_div();
      bit seen;
      @(negedge clk);
      per_vld = 1'b1;
      cadence_per = 8'h80;
      @(posedge clk);
      #1;
      per_vld = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      checks++;
      if (cadence !== 5'd0 || cadence_vld !== 1'b0 || busy !== 1'b0 || per_rdy !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset_state: cad=%h vld=%b busy=%b rdy=%b want 00 0 0 1",
                  cadence, cadence_vld, busy, per_rdy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (cadence_vld) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_strobe: got strobe=%b want 0", seen);
      end
      run_one("after_rst", 8'h80);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_divide();
      test_saturate();
      test_back_to_back();
      test_random();
      test_reset_mid_div();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
